dmem_dump_ctrl: RTL and testbench

Halt-triggered data-memory dump controller sitting between the CPU's MEM stage and the data memory array. During normal execution it passes MEM-stage accesses straight through. On fetch of the halt word it:
- freezes fetch;
- drains the in-flight pipeline;
- takes ownership of the memory port;
- streams every data-memory word out over a valid/ready interface, so benches and debug hosts read final memory contents through RTL instead of hierarchical peeks.

---
 rtl/dmem_dump_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_dump_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_ctrl.sv
// Halt-triggered data-memory dump controller: passes MEM-stage accesses through,
// then on the halt word drains the pipeline and streams every memory word out.
module dmem_dump_ctrl #(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 32,
  parameter int          DEPTH        = 1024,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              cpu_mem_en,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_hold,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              done,
  output logic              cpu_conflict
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    DRAIN = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    SHOW  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic [CNT_W-1:0]  drain_cnt_r, drain_cnt_s;
  logic              owns_port_s;

  assign cpu_rdata = mem_rdata;

  // Next-state, pointer/counter update and memory-port mux
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    drain_cnt_s = drain_cnt_r;
    owns_port_s = 1'b1;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = ptr_r;
    mem_wdata   = {DATA_W{1'b0}};
    dump_valid  = 1'b0;
    done        = 1'b0;
    case (state_r)
      RUN: begin
        owns_port_s = 1'b0;
        if (instruction == HALT_WORD) begin
          state_s     = DRAIN;
          drain_cnt_s = DRAIN_LOAD;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        owns_port_s = 1'b0;
        if (drain_cnt_r == {CNT_W{1'b0}}) begin
          state_s = READ;
          ptr_s   = {ADDR_W{1'b0}};
        end else begin
          drain_cnt_s = drain_cnt_r - CNT_W'(1);
        end
      end
      READ: begin
        mem_en  = 1'b1;
        state_s = WAIT;
      end
      WAIT: begin
        state_s = SHOW;
      end
      SHOW: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (dump_last) begin
            state_s = DONE;
          end else begin
            ptr_s   = ptr_r + ADDR_W'(1);
            state_s = READ;
          end
        end else begin
          state_s = SHOW;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_s = RUN;
      end
    endcase
    // The CPU keeps the port until the drain window closes
    if (!owns_port_s) begin
      mem_en    = cpu_mem_en;
      mem_we    = cpu_mem_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_we = 1'b0;
    end
  end

  // State, pointer and drain counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      ptr_r       <= {ADDR_W{1'b0}};
      drain_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Registered status outputs and the captured dump word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_hold   <= 1'b0;
      cpu_conflict <= 1'b0;
      dump_data    <= {DATA_W{1'b0}};
      dump_addr    <= {ADDR_W{1'b0}};
      dump_last    <= 1'b0;
    end else begin
      if (state_s != RUN) begin
        fetch_hold <= 1'b1;
      end
      if (owns_port_s && cpu_mem_en) begin
        cpu_conflict <= 1'b1;
      end
      if (state_r == WAIT) begin
        dump_data <= mem_rdata;
        dump_addr <= ptr_r;
        dump_last <= (ptr_r == LAST_ADDR);
      end
    end
  end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: behavioural memory + phase model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_dump_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int DRAIN = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   instruction = 32'd0;
  logic          cpu_mem_en = 1'b0;
  logic          cpu_mem_we = 1'b0;
  logic [AW-1:0] cpu_addr = 4'd0;
  logic [DW-1:0] cpu_wdata = 32'd0;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          fetch_hold, dump_valid, dump_last, done, cpu_conflict;
  logic          dump_ready = 1'b0;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;

  dmem_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN),
                   .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .cpu_mem_en(cpu_mem_en), .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fetch_hold(fetch_hold), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .done(done), .cpu_conflict(cpu_conflict));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic preload = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous data memory, read data valid the cycle after the request
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'(i * 3);
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Model: phase 0 run, 1 drain, 2 dump, 3 done; step 0 read, 1 wait, 2 show
  logic [DW-1:0] ref_mem [16];
  int m_phase = 0, m_left = 0, m_word = 0, m_step = 0;
  bit m_hold = 1'b0, m_conf = 1'b0;

  // Event log of the DUT for the timing literals
  bit mon_arm = 1'b0;
  int d_hold, d_read, d_read_addr, d_done;
  int hs_cyc[$];
  int hs_addr[$];
  logic [31:0] hs_data[$];
  bit hs_last[$];

  always @(negedge clk) begin
    if (preload) for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i * 3);
    if (!rst) begin
      m_phase = 0; m_left = 0; m_word = 0; m_step = 0; m_hold = 1'b0; m_conf = 1'b0;
    end
    check("fetch_hold", 32'(fetch_hold), 32'(m_hold));
    check("done", 32'(done), 32'(m_phase == 3));
    check("dump_valid", 32'(dump_valid), 32'(m_phase == 2 && m_step == 2));
    check("cpu_conflict", 32'(cpu_conflict), 32'(m_conf));
    check("cpu_rdata", cpu_rdata, mem_rdata);
    if (m_phase <= 1) begin
      check("mem_en_pass", 32'(mem_en), 32'(cpu_mem_en));
      if (cpu_mem_en) begin
        check("mem_we_pass", 32'(mem_we), 32'(cpu_mem_we));
        check("mem_addr_pass", 32'(mem_addr), 32'(cpu_addr));
        if (cpu_mem_we) check("mem_wdata_pass", mem_wdata, cpu_wdata);
      end
    end else if (m_phase == 2 && m_step == 0) begin
      check("read_en", 32'(mem_en), 32'd1);
      check("read_we", 32'(mem_we), 32'd0);
      check("read_addr", 32'(mem_addr), 32'(m_word));
      check("read_wdata", mem_wdata, 32'd0);
    end else begin
      check("mem_idle", 32'(mem_en), 32'd0);
    end
    if (m_phase == 2 && m_step == 2) begin
      check("dump_data", dump_data, ref_mem[m_word]);
      check("dump_addr", 32'(dump_addr), 32'(m_word));
      check("dump_last", 32'(dump_last), 32'(m_word == DEPTH - 1));
    end else if (!rst) begin
      check("rst_dump_data", dump_data, 32'd0);
      check("rst_dump_addr", 32'(dump_addr), 32'd0);
      check("rst_dump_last", 32'(dump_last), 32'd0);
    end
    if (mon_arm) begin
      if (fetch_hold && d_hold < 0) d_hold = cyc;
      if (fetch_hold && mem_en && !mem_we && d_read < 0) begin
        d_read = cyc; d_read_addr = int'(mem_addr);
      end
      if (dump_valid && dump_ready) begin
        hs_cyc.push_back(cyc); hs_addr.push_back(int'(dump_addr));
        hs_data.push_back(dump_data); hs_last.push_back(dump_last);
      end
      if (done && d_done < 0) d_done = cyc;
    end
    if (rst) begin
      case (m_phase)
        0, 1: begin
          if (cpu_mem_en && cpu_mem_we) ref_mem[cpu_addr] = cpu_wdata;
          if (m_phase == 0 && instruction == HALT) begin
            m_phase = 1; m_left = DRAIN; m_hold = 1'b1;
          end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin m_phase = 2; m_word = 0; m_step = 0; end
          end
        end
        2: begin
          if (cpu_mem_en) m_conf = 1'b1;
          if (m_step < 2) m_step++;
          else if (dump_ready) begin
            if (m_word == DEPTH - 1) m_phase = 3;
            else begin m_word++; m_step = 0; end
          end
        end
        default: if (cpu_mem_en) m_conf = 1'b1;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic arm();
    hs_cyc.delete(); hs_addr.delete(); hs_data.delete(); hs_last.delete();
    d_hold = -1; d_read = -1; d_read_addr = -1; d_done = -1; mon_arm = 1'b1;
  endtask

  task automatic wait_show(input int a, input int budget);
    int k = 0;
    while (!(dump_valid && dump_addr == AW'(a)) && k < budget) begin step(); k++; end
    if (k >= budget) begin
      n_total++;
      $display("FAIL wait_show: no dump_valid at addr %0d within %0d cycles", a, budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin step(); k++; end
    if (k >= budget) begin
      n_total++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
    step();
  endtask

  int h;
  int found;

  initial begin
    step(); step(); preload = 1'b0;
    check("rst_fetch_hold", 32'(fetch_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_conflict", 32'(cpu_conflict), 32'd0);
    rst = 1'b1; step();

    // Pass-through write then read of addr 5
    cpu_mem_en = 1'b1; cpu_mem_we = 1'b1; cpu_addr = 4'd5; cpu_wdata = 32'hDEADBEEF; #1;
    check("pt_we", 32'(mem_we), 32'd1);
    check("pt_addr", 32'(mem_addr), 32'd5);
    check("pt_wdata", mem_wdata, 32'hDEADBEEF);
    step(); cpu_mem_we = 1'b0; cpu_wdata = 32'd0; #1;
    check("pt_rd_en", 32'(mem_en), 32'd1);
    step(); cpu_mem_en = 1'b0;
    check("pt_rdata", cpu_rdata, 32'hDEADBEEF);
    check("pt_hold", 32'(fetch_hold), 32'd0);
    cpu_mem_en = 1'b1; cpu_mem_we = 1'b1; cpu_addr = 4'd5; cpu_wdata = 32'd15;
    step(); cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_wdata = 32'd0; step();

    // Full dump with ready high; h is the edge that samples the halt word
    dump_ready = 1'b1; arm();
    instruction = HALT; h = cyc + 1; step(); instruction = 32'd0;
    wait_done(80);
    check("full_hold_cycle", 32'(d_hold), 32'(h));
    check("full_first_read", 32'(d_read), 32'(h + 4));
    check("full_hs_count", 32'(hs_cyc.size()), 32'd8);
    if (hs_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("full_data", hs_data[i], 32'(3 * i));
        check("full_addr", 32'(hs_addr[i]), 32'(i));
        check("full_last", 32'(hs_last[i]), 32'(i == 7));
      end
      check("full_first_hs", 32'(hs_cyc[0]), 32'(h + 6));
      check("full_span", 32'(hs_cyc[7] - d_read + 1), 32'd24);
      check("full_done_cycle", 32'(d_done), 32'(hs_cyc[7] + 1));
    end
    rst = 1'b0; step(); rst = 1'b1; step();

    // Drain-window store, backpressure at addr 2, conflict at addr 5
    arm(); dump_ready = 1'b1;
    instruction = HALT; step(); instruction = 32'd0; step(); step(); step();
    cpu_mem_en = 1'b1; cpu_mem_we = 1'b1; cpu_addr = 4'd6; cpu_wdata = 32'h12345678; #1;
    check("drain_store_fwd", 32'(mem_we), 32'd1);
    step(); cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_wdata = 32'd0;
    wait_show(2, 40);
    dump_ready = 1'b0;
    repeat (10) step();
    check("bp_valid", 32'(dump_valid), 32'd1);
    check("bp_addr", 32'(dump_addr), 32'd2);
    check("bp_data", dump_data, 32'd6);
    check("bp_mem_idle", 32'(mem_en), 32'd0);
    dump_ready = 1'b1; step();
    check("bp_next_en", 32'(mem_en), 32'd1);
    check("bp_next_addr", 32'(mem_addr), 32'd3);
    wait_show(5, 40);
    check("pre_conflict", 32'(cpu_conflict), 32'd0);
    cpu_mem_en = 1'b1; cpu_mem_we = 1'b1; cpu_addr = 4'd5; cpu_wdata = 32'hBAD0BAD0;
    step(); cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_wdata = 32'd0;
    wait_done(60);
    check("conflict_sticky", 32'(cpu_conflict), 32'd1);
    check("conflict_done", 32'(done), 32'd1);
    check("conflict_no_write", ram[5], 32'd15);
    found = 0;
    foreach (hs_addr[i]) if (hs_addr[i] == 6) begin
      found = 1; check("drain_store_dump", hs_data[i], 32'h12345678);
    end
    check("drain_store_seen", 32'(found), 32'd1);
    rst = 1'b0; step(); rst = 1'b1; step();

    // Reset while showing addr 4, then a fresh dump from addr 0
    arm(); instruction = HALT; step(); instruction = 32'd0;
    wait_show(4, 40);
    rst = 1'b0; #1;
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_hold", 32'(fetch_hold), 32'd0);
    check("mid_rst_addr", 32'(dump_addr), 32'd0);
    check("mid_rst_data", dump_data, 32'd0);
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    step(); rst = 1'b1; step(); step();
    arm(); instruction = HALT; step(); instruction = 32'd0;
    wait_done(60);
    check("restart_first_read", 32'(d_read_addr), 32'd0);
    check("restart_hs_count", 32'(hs_addr.size()), 32'd8);
    if (hs_addr.size() > 0) check("restart_first_addr", 32'(hs_addr[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
